// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with four-way write-back result selection and
// sub-word load extraction (byte/halfword, sign or zero extended).
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LANE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              StallW,
  input  logic              FlushW,
  input  logic              RegWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [2:0]        LoadTypeM,
  input  logic [ADDR_W-1:0] WriteRegM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] ReadDataM,
  input  logic [DATA_W-1:0] PCPlus8M,
  input  logic [DATA_W-1:0] HiLoM,
  output logic              RegWriteW,
  output logic [ADDR_W-1:0] WriteRegW,
  output logic [DATA_W-1:0] ResultW,
  output logic              ValidW,
  output logic              AlignErrW
);

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_MEM  = 2'b01;
  localparam logic [1:0] SRC_LINK = 2'b10;

  localparam logic [2:0] LD_BYTE_S = 3'b001;
  localparam logic [2:0] LD_BYTE_U = 3'b010;
  localparam logic [2:0] LD_HALF_S = 3'b011;
  localparam logic [2:0] LD_HALF_U = 3'b100;

  logic              reg_write_p0;
  logic [1:0]        result_src_p0;
  logic [2:0]        load_type_p0;
  logic [ADDR_W-1:0] write_reg_p0;
  logic [DATA_W-1:0] alu_out_p0;
  logic [DATA_W-1:0] read_data_p0;
  logic [DATA_W-1:0] pc_plus8_p0;
  logic [DATA_W-1:0] hi_lo_p0;
  logic              vld_p0;

  // Lane-select and extend a loaded value; halfwords use the even lane at or
  // below the address so a misaligned access still yields debuggable data.
  function automatic logic [DATA_W-1:0] load_extract(
    input logic [2:0]        load_type,
    input logic [DATA_W-1:0] data,
    input logic [LANE_W-1:0] lane
  );
    logic signed [7:0]  byte_val;
    logic signed [15:0] half_val;
    logic [LANE_W-1:0]  half_lane;
    half_lane = {lane[LANE_W-1:1], 1'b0};
    byte_val  = data[8*int'(lane) +: 8];
    half_val  = data[8*int'(half_lane) +: 16];
    case (load_type)
      LD_BYTE_S: load_extract = {{(DATA_W-8){byte_val[7]}}, byte_val};
      LD_BYTE_U: load_extract = {{(DATA_W-8){1'b0}}, byte_val};
      LD_HALF_S: load_extract = {{(DATA_W-16){half_val[15]}}, half_val};
      LD_HALF_U: load_extract = {{(DATA_W-16){1'b0}}, half_val};
      default:   load_extract = data;
    endcase
  endfunction

  // Stage p0: W-stage register; flush beats stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0        <= 1'b0;
      reg_write_p0  <= 1'b0;
      result_src_p0 <= SRC_ALU;
      load_type_p0  <= 3'b000;
      write_reg_p0  <= '0;
      alu_out_p0    <= '0;
      read_data_p0  <= '0;
      pc_plus8_p0   <= '0;
      hi_lo_p0      <= '0;
    end else if (FlushW) begin
      vld_p0        <= 1'b0;
      reg_write_p0  <= 1'b0;
      result_src_p0 <= SRC_ALU;
      load_type_p0  <= 3'b000;
      write_reg_p0  <= '0;
      alu_out_p0    <= '0;
      read_data_p0  <= '0;
      pc_plus8_p0   <= '0;
      hi_lo_p0      <= '0;
    end else if (!StallW) begin
      vld_p0        <= 1'b1;
      reg_write_p0  <= RegWriteM;
      result_src_p0 <= ResultSrcM;
      load_type_p0  <= LoadTypeM;
      write_reg_p0  <= WriteRegM;
      alu_out_p0    <= ALUOutM;
      read_data_p0  <= ReadDataM;
      pc_plus8_p0   <= PCPlus8M;
      hi_lo_p0      <= HiLoM;
    end
  end

  always_comb begin
    case (result_src_p0)
      SRC_ALU:  ResultW = alu_out_p0;
      SRC_MEM:  ResultW = load_extract(load_type_p0, read_data_p0, alu_out_p0[LANE_W-1:0]);
      SRC_LINK: ResultW = pc_plus8_p0;
      default:  ResultW = hi_lo_p0;
    endcase
  end

  // Word alignment is enforced upstream; only halfword loads are checked here.
  assign AlignErrW = (result_src_p0 == SRC_MEM) && alu_out_p0[0] &&
                     ((load_type_p0 == LD_HALF_S) || (load_type_p0 == LD_HALF_U));
  assign RegWriteW = reg_write_p0 & vld_p0 & ~AlignErrW;
  assign WriteRegW = write_reg_p0;
  assign ValidW    = vld_p0;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: expected W-stage outputs are queued as
// each M-stage transaction is driven and compared one cycle later.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StallW = 1'b0;
  logic        FlushW = 1'b0;
  logic        RegWriteM = 1'b0;
  logic [1:0]  ResultSrcM = 2'b00;
  logic [2:0]  LoadTypeM = 3'b000;
  logic [4:0]  WriteRegM = '0;
  logic [31:0] ALUOutM = '0;
  logic [31:0] ReadDataM = '0;
  logic [31:0] PCPlus8M = '0;
  logic [31:0] HiLoM = '0;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic        ValidW;
  logic        AlignErrW;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] res;
    logic        v;
    logic        ae;
  } exp_t;

  exp_t sb_q[$];

  writeback_stage #(.DATA_W(32), .ADDR_W(5), .LANE_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .StallW(StallW), .FlushW(FlushW),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .LoadTypeM(LoadTypeM),
    .WriteRegM(WriteRegM), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
    .PCPlus8M(PCPlus8M), .HiLoM(HiLoM), .RegWriteW(RegWriteW),
    .WriteRegW(WriteRegW), .ResultW(ResultW), .ValidW(ValidW),
    .AlignErrW(AlignErrW)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic rw, input logic [4:0] wr,
                              input logic [31:0] res, input logic v, input logic ae);
    exp_t e;
    e.rw = rw; e.wr = wr; e.res = res; e.v = v; e.ae = ae;
    return e;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".rw"},  32'(RegWriteW), 32'(e.rw));
    check({tag, ".wr"},  32'(WriteRegW), 32'(e.wr));
    check({tag, ".res"}, ResultW, e.res);
    check({tag, ".v"},   32'(ValidW), 32'(e.v));
    check({tag, ".ae"},  32'(AlignErrW), 32'(e.ae));
  endtask

  task automatic drive(input logic rw, input logic [1:0] src, input logic [2:0] lt,
                       input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] rd,
                       input logic [31:0] pc, input logic [31:0] hl);
    @(negedge clk);
    RegWriteM = rw; ResultSrcM = src; LoadTypeM = lt; WriteRegM = wr;
    ALUOutM = alu; ReadDataM = rd; PCPlus8M = pc; HiLoM = hl;
  endtask

  task automatic step(input string tag, input exp_t e);
    exp_t got_e;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got_e = sb_q.pop_front();
    check_outputs(tag, got_e);
  endtask

  // Reference load extraction written with shifts and masks.
  function automatic logic [31:0] ref_load(input logic [2:0] lt, input logic [31:0] rd,
                                           input logic [1:0] lane);
    logic [31:0] b, h;
    b = (rd >> (8 * lane)) & 32'hFF;
    h = (rd >> (lane[1] ? 16 : 0)) & 32'hFFFF;
    case (lt)
      3'd1:    return (b & 32'h80) != 0 ? (b | 32'hFFFF_FF00) : b;
      3'd2:    return b;
      3'd3:    return (h & 32'h8000) != 0 ? (h | 32'hFFFF_0000) : h;
      3'd4:    return h;
      default: return rd;
    endcase
  endfunction

  initial begin
    exp_t held;
    #2;
    check_outputs("reset_init", mk(0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    drive(1, 2'b00, 3'd0, 5'd8, 32'h0000_1234, 32'h0, 32'h0, 32'h0);
    step("alu", mk(1, 8, 32'h0000_1234, 1, 0));

    // Asynchronous reset mid-cycle with live state.
    #2 rst_n = 1'b0;
    #1 check_outputs("reset_async", mk(0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    drive(1, 2'b01, 3'd1, 5'd3, 32'h0000_1003, 32'h80FF_7F01, 32'h0, 32'h0);
    step("lb_s_l3", mk(1, 3, 32'hFFFF_FF80, 1, 0));
    drive(1, 2'b01, 3'd2, 5'd3, 32'h0000_1003, 32'h80FF_7F01, 32'h0, 32'h0);
    step("lb_u_l3", mk(1, 3, 32'h0000_0080, 1, 0));
    drive(1, 2'b01, 3'd1, 5'd4, 32'h0000_1000, 32'h80FF_7F01, 32'h0, 32'h0);
    step("lb_s_l0", mk(1, 4, 32'h0000_0001, 1, 0));
    drive(1, 2'b01, 3'd1, 5'd4, 32'h0000_1001, 32'h80FF_7F01, 32'h0, 32'h0);
    step("lb_s_l1", mk(1, 4, 32'h0000_007F, 1, 0));
    drive(1, 2'b01, 3'd1, 5'd4, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 32'h0);
    step("lb_s_l2", mk(1, 4, 32'hFFFF_FFFF, 1, 0));
    drive(1, 2'b01, 3'd3, 5'd9, 32'h0000_2002, 32'h8001_1234, 32'h0, 32'h0);
    step("lh_s_l2", mk(1, 9, 32'hFFFF_8001, 1, 0));
    drive(1, 2'b01, 3'd4, 5'd9, 32'h0000_2002, 32'h8001_1234, 32'h0, 32'h0);
    step("lh_u_l2", mk(1, 9, 32'h0000_8001, 1, 0));
    drive(1, 2'b01, 3'd3, 5'd9, 32'h0000_2001, 32'h8001_1234, 32'h0, 32'h0);
    step("lh_misalign", mk(0, 9, 32'h0000_1234, 1, 1));
    drive(1, 2'b01, 3'd4, 5'd9, 32'h0000_2003, 32'h8001_1234, 32'h0, 32'h0);
    step("lhu_misalign", mk(0, 9, 32'h0000_8001, 1, 1));
    drive(1, 2'b01, 3'd0, 5'd10, 32'h0000_2003, 32'hCAFE_F00D, 32'h0, 32'h0);
    step("lw", mk(1, 10, 32'hCAFE_F00D, 1, 0));
    drive(1, 2'b01, 3'd7, 5'd10, 32'h0000_2001, 32'h1357_9BDF, 32'h0, 32'h0);
    step("ld_rsvd", mk(1, 10, 32'h1357_9BDF, 1, 0));
    drive(1, 2'b00, 3'd3, 5'd11, 32'h0000_0001, 32'h0, 32'h0, 32'h0);
    step("alu_odd_half", mk(1, 11, 32'h0000_0001, 1, 0));
    drive(1, 2'b10, 3'd0, 5'd31, 32'h0, 32'h0, 32'h0040_0008, 32'h0);
    step("link", mk(1, 31, 32'h0040_0008, 1, 0));
    drive(0, 2'b11, 3'd0, 5'd12, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF);
    step("hilo_nowr", mk(0, 12, 32'hDEAD_BEEF, 1, 0));
    drive(1, 2'b11, 3'd0, 5'd12, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF);
    step("hilo", mk(1, 12, 32'hDEAD_BEEF, 1, 0));

    for (int i = 0; i < 12; i++) begin
      logic [31:0] rd, alu;
      logic [2:0]  lt;
      logic [4:0]  wr;
      logic        ae;
      rd  = $urandom;
      alu = $urandom;
      lt  = 3'($urandom_range(0, 7));
      wr  = 5'($urandom_range(0, 31));
      ae  = ((lt == 3'd3) || (lt == 3'd4)) && alu[0];
      drive(1, 2'b01, lt, wr, alu, rd, 32'h0, 32'h0);
      step("rand_load", mk(~ae, wr, ref_load(lt, rd, alu[1:0]), 1, ae));
    end

    // Hold for three cycles while M inputs keep changing.
    held = mk(1, 5'd7, 32'h0BAD_F00D, 1, 0);
    drive(1, 2'b00, 3'd0, 5'd7, 32'h0BAD_F00D, 32'h0, 32'h0, 32'h0);
    step("pre_stall", held);
    for (int i = 0; i < 3; i++) begin
      drive(0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 5'($urandom),
            $urandom, $urandom, $urandom, $urandom);
      StallW = 1'b1;
      step("stall", held);
    end

    drive(1, 2'b11, 3'd0, 5'd13, 32'h0, 32'h0, 32'h0, 32'h1111_2222);
    FlushW = 1'b1;
    step("stall_flush", mk(0, 0, 0, 0, 0));
    StallW = 1'b0;
    FlushW = 1'b0;
    drive(1, 2'b11, 3'd0, 5'd13, 32'h0, 32'h0, 32'h0, 32'h1111_2222);
    step("post_flush", mk(1, 13, 32'h1111_2222, 1, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
